// File: rtl/mpsoc_pkg.sv
// Shared tile definitions: AXI4 slave bundles, NoC IRQ bundle, the IRQ
// controller register map and AXI response encodings.
package mpsoc_pkg;

   localparam int N_VIRT_CHN = 3;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_ID_W   = 4;

   localparam logic [31:0] IRQ_BASE_ADDR = 32'hB000_0000;

   localparam logic [11:0] IRQ_OFF_PENDING = 12'h000;
   localparam logic [11:0] IRQ_OFF_ENABLE  = 12'h004;
   localparam logic [11:0] IRQ_OFF_CLEAR   = 12'h008;
   localparam logic [11:0] IRQ_OFF_RAW     = 12'h00C;

   localparam logic [1:0] AXI_OKAY   = 2'b00;
   localparam logic [1:0] AXI_SLVERR = 2'b10;

   typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wr_state_e;
   typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

   typedef struct packed {
      logic [AXI_ID_W-1:0]     awid;
      logic [AXI_ADDR_W-1:0]   awaddr;
      logic [7:0]              awlen;
      logic [2:0]              awsize;
      logic [1:0]              awburst;
      logic                    awvalid;
      logic [AXI_DATA_W-1:0]   wdata;
      logic [AXI_DATA_W/8-1:0] wstrb;
      logic                    wlast;
      logic                    wvalid;
      logic                    bready;
      logic [AXI_ID_W-1:0]     arid;
      logic [AXI_ADDR_W-1:0]   araddr;
      logic [7:0]              arlen;
      logic [2:0]              arsize;
      logic [1:0]              arburst;
      logic                    arvalid;
      logic                    rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic                  awready;
      logic                  wready;
      logic [AXI_ID_W-1:0]   bid;
      logic [1:0]            bresp;
      logic                  bvalid;
      logic                  arready;
      logic [AXI_ID_W-1:0]   rid;
      logic [AXI_DATA_W-1:0] rdata;
      logic [1:0]            rresp;
      logic                  rlast;
      logic                  rvalid;
   } s_axi_miso_t;

   typedef struct packed {
      logic [N_VIRT_CHN-1:0] irq_vcs;
   } s_irq_ni_t;

   // Any of the four registers (readable offsets)
   function automatic logic irq_reg_mapped(input logic [11:0] off);
      return (off == IRQ_OFF_PENDING) || (off == IRQ_OFF_ENABLE) ||
             (off == IRQ_OFF_CLEAR)   || (off == IRQ_OFF_RAW);
   endfunction

   // Registers that accept writes
   function automatic logic irq_reg_writable(input logic [11:0] off);
      return (off == IRQ_OFF_ENABLE) || (off == IRQ_OFF_CLEAR);
   endfunction

endpackage

// File: rtl/tile_irq_edge.sv
// One IRQ source: registered copy of the level, rising-edge detect and a
// sticky pending bit. A set and clear in the same cycle leaves the bit set.
module tile_irq_edge (
   input  logic clk,
   input  logic rst,
   input  logic arm,
   input  logic irq,
   input  logic clr,
   output logic sync_q,
   output logic pending
);

   logic rise;

   // arm is low for the first cycle after reset so a level already high at
   // release is absorbed into sync_q instead of being seen as an edge
   assign rise = arm & irq & ~sync_q;

   // Registered copy of the source level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= 1'b0;
      else     sync_q <= irq;
   end

   // Pending bit, set wins over clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       pending <= 1'b0;
      else if (rise) pending <= 1'b1;
      else if (clr)  pending <= 1'b0;
   end

endmodule

// File: rtl/tile_irq_ctrl.sv
// Tile interrupt controller: latches NoC IRQ edges into PENDING, masks with
// ENABLE and drives a level interrupt to the core. Registers sit behind a
// single-beat AXI4 slave with independent read and write FSMs.
module tile_irq_ctrl
   import mpsoc_pkg::*;
#(
   parameter int          N_SRC     = N_VIRT_CHN,
   parameter logic [31:0] BASE_ADDR = IRQ_BASE_ADDR
) (
   input  logic        clk_core,
   input  logic        arst_core,
   input  s_axi_mosi_t axi_mosi,
   output s_axi_miso_t axi_miso,
   input  s_irq_ni_t   irqs_noc,
   output logic        irq_o
);

   logic [N_SRC-1:0] pending, enable, raw, clr_vec, en_we;
   logic             armed;

   // write path state
   wr_state_e             w_state, w_next;
   logic                  aw_held, w_held, aw_burst;
   logic [AXI_ID_W-1:0]   aw_id, b_id;
   logic [11:0]           aw_off;
   logic [AXI_DATA_W-1:0] w_data;
   logic [AXI_DATA_W/8-1:0] w_strb;
   logic [1:0]            b_resp;
   logic                  awready, wready, bvalid;
   logic                  wr_go, wr_err;

   // read path state
   rd_state_e             r_state, r_next;
   logic [AXI_ID_W-1:0]   r_id;
   logic [AXI_DATA_W-1:0] r_data, rd_val;
   logic [1:0]            r_resp;
   logic [7:0]            r_len, r_cnt;
   logic                  arready, rvalid, rlast;

   logic unused_ok;
   assign unused_ok = ^{BASE_ADDR, axi_mosi, irqs_noc, w_data, w_strb};

   // Edge detection is held off for one cycle after reset release
   always_ff @(posedge clk_core or posedge arst_core) begin
      if (arst_core) armed <= 1'b0;
      else           armed <= 1'b1;
   end

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      assign en_we[i]   = wr_go & ~wr_err & (aw_off == IRQ_OFF_ENABLE) & w_strb[i/8];
      assign clr_vec[i] = wr_go & ~wr_err & (aw_off == IRQ_OFF_CLEAR) & w_strb[i/8] & w_data[i];

      tile_irq_edge u_edge (
         .clk     (clk_core),
         .rst     (arst_core),
         .arm     (armed),
         .irq     (irqs_noc.irq_vcs[i]),
         .clr     (clr_vec[i]),
         .sync_q  (raw[i]),
         .pending (pending[i])
      );
   end

   // ENABLE register, byte-strobed
   always_ff @(posedge clk_core or posedge arst_core) begin
      if (arst_core) enable <= '0;
      else begin
         for (int i = 0; i < N_SRC; i++)
            if (en_we[i]) enable[i] <= w_data[i];
      end
   end

   // Registered level interrupt to the core
   always_ff @(posedge clk_core or posedge arst_core) begin
      if (arst_core) irq_o <= 1'b0;
      else           irq_o <= |(pending & enable);
   end

   // ---------------- write path ----------------
   assign wr_go  = (w_state == W_IDLE) & aw_held & w_held;
   assign wr_err = aw_burst | ~irq_reg_writable(aw_off);

   // Write FSM state register
   always_ff @(posedge clk_core or posedge arst_core) begin
      if (arst_core) w_state <= W_IDLE;
      else           w_state <= w_next;
   end

   // Write FSM next state
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_held && w_held) w_next = W_RESP;
         W_RESP:  if (axi_mosi.bready)   w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Write FSM outputs; each channel stops accepting once its half is held
   always_comb begin
      awready = (w_state == W_IDLE) & ~aw_held;
      wready  = (w_state == W_IDLE) & ~w_held;
      bvalid  = (w_state == W_RESP);
   end

   // AW/W capture and response latch; burst beats are drained up to wlast
   always_ff @(posedge clk_core or posedge arst_core) begin
      if (arst_core) begin
         aw_held  <= 1'b0;
         w_held   <= 1'b0;
         aw_burst <= 1'b0;
         aw_id    <= '0;
         aw_off   <= '0;
         w_data   <= '0;
         w_strb   <= '0;
         b_id     <= '0;
         b_resp   <= AXI_OKAY;
      end else if (wr_go) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         b_id    <= aw_id;
         b_resp  <= wr_err ? AXI_SLVERR : AXI_OKAY;
      end else begin
         if (axi_mosi.awvalid && awready) begin
            aw_held  <= 1'b1;
            aw_id    <= axi_mosi.awid;
            aw_off   <= axi_mosi.awaddr[11:0];
            aw_burst <= (axi_mosi.awlen != 8'd0);
         end
         if (axi_mosi.wvalid && wready) begin
            w_data <= axi_mosi.wdata;
            w_strb <= axi_mosi.wstrb;
            if (axi_mosi.wlast) w_held <= 1'b1;
         end
      end
   end

   // ---------------- read path ----------------
   // Register read mux, unused upper bits read 0
   always_comb begin
      rd_val = '0;
      case (axi_mosi.araddr[11:0])
         IRQ_OFF_PENDING: rd_val[N_SRC-1:0] = pending;
         IRQ_OFF_ENABLE:  rd_val[N_SRC-1:0] = enable;
         IRQ_OFF_RAW:     rd_val[N_SRC-1:0] = raw;
         default:         rd_val = '0;
      endcase
   end

   // Read FSM state register
   always_ff @(posedge clk_core or posedge arst_core) begin
      if (arst_core) r_state <= R_IDLE;
      else           r_state <= r_next;
   end

   // Read FSM next state
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (axi_mosi.arvalid)          r_next = R_DATA;
         R_DATA:  if (axi_mosi.rready && rlast)  r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Read FSM outputs
   always_comb begin
      arready = (r_state == R_IDLE);
      rvalid  = (r_state == R_DATA);
      rlast   = (r_state == R_DATA) && (r_cnt == r_len);
   end

   // Data captured once at AR handshake; bursts and holes return SLVERR/0
   always_ff @(posedge clk_core or posedge arst_core) begin
      if (arst_core) begin
         r_id   <= '0;
         r_data <= '0;
         r_resp <= AXI_OKAY;
         r_len  <= '0;
         r_cnt  <= '0;
      end else if (arready && axi_mosi.arvalid) begin
         r_id  <= axi_mosi.arid;
         r_len <= axi_mosi.arlen;
         r_cnt <= '0;
         if ((axi_mosi.arlen != 8'd0) || !irq_reg_mapped(axi_mosi.araddr[11:0])) begin
            r_data <= '0;
            r_resp <= AXI_SLVERR;
         end else begin
            r_data <= rd_val;
            r_resp <= AXI_OKAY;
         end
      end else if (rvalid && axi_mosi.rready && !rlast) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Pack slave response bundle
   always_comb begin
      axi_miso         = '0;
      axi_miso.awready = awready;
      axi_miso.wready  = wready;
      axi_miso.bid     = b_id;
      axi_miso.bresp   = b_resp;
      axi_miso.bvalid  = bvalid;
      axi_miso.arready = arready;
      axi_miso.rid     = r_id;
      axi_miso.rdata   = r_data;
      axi_miso.rresp   = r_resp;
      axi_miso.rlast   = rlast;
      axi_miso.rvalid  = rvalid;
   end

endmodule

// File: tb/tb_tile_irq_ctrl.sv
// Bench for tile_irq_ctrl: register-access vector table, hand sequences for
// the multi-cycle corners, then random traffic against a transaction model.
module tb_tile_irq_ctrl;
   import mpsoc_pkg::*;

   localparam int          NS   = N_VIRT_CHN;
   localparam logic [31:0] MASK = 32'((64'd1 << NS) - 1);
   localparam logic [31:0] BASE = 32'hB000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   s_axi_mosi_t mosi;
   s_axi_miso_t miso;
   s_irq_ni_t   irqs;
   logic        irq_o;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   tile_irq_ctrl #(.N_SRC(NS), .BASE_ADDR(BASE)) dut (
      .clk_core (clk),
      .arst_core(rst),
      .axi_mosi (mosi),
      .axi_miso (miso),
      .irqs_noc (irqs),
      .irq_o    (irq_o)
   );

   typedef struct {
      logic        wr;
      logic [11:0] off;
      logic [31:0] data;
      logic [1:0]  resp;
      logic [31:0] rdata;
   } vec_t;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, 32'(act), 32'(exp));
   endtask

   task automatic axi_wr(input logic [11:0] off, input logic [31:0] data,
                         input logic [3:0] strb, input logic [3:0] id,
                         output logic [1:0] resp);
      int   n;
      logic a, w;
      mosi.awid = id; mosi.awaddr = BASE | {20'h0, off}; mosi.awlen = 8'd0;
      mosi.awvalid = 1'b1;
      mosi.wdata = data; mosi.wstrb = strb; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
      mosi.bready = 1'b1;
      n = 0;
      while ((mosi.awvalid || mosi.wvalid) && n < 20) begin
         a = mosi.awvalid & miso.awready;
         w = mosi.wvalid & miso.wready;
         tick;
         if (a) mosi.awvalid = 1'b0;
         if (w) mosi.wvalid = 1'b0;
         n++;
      end
      chk("wr_accept", {30'd0, mosi.awvalid, mosi.wvalid}, 32'd0);
      mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
      n = 0;
      while (!miso.bvalid && n < 20) begin tick; n++; end
      chk1("wr_bvalid", miso.bvalid, 1'b1);
      chk("wr_bid", 32'(miso.bid), 32'(id));
      resp = miso.bresp;
      tick;
      mosi.bready = 1'b0;
   endtask

   task automatic axi_rd(input logic [11:0] off, input logic [3:0] id,
                         output logic [31:0] data, output logic [1:0] resp);
      int n;
      mosi.arid = id; mosi.araddr = BASE | {20'h0, off}; mosi.arlen = 8'd0;
      mosi.arvalid = 1'b1; mosi.rready = 1'b1;
      n = 0;
      while (!miso.arready && n < 20) begin tick; n++; end
      tick;
      mosi.arvalid = 1'b0;
      n = 0;
      while (!miso.rvalid && n < 20) begin tick; n++; end
      chk1("rd_rvalid", miso.rvalid, 1'b1);
      chk("rd_rid", 32'(miso.rid), 32'(id));
      chk1("rd_rlast", miso.rlast, 1'b1);
      data = miso.rdata;
      resp = miso.rresp;
      tick;
      mosi.rready = 1'b0;
   endtask

   task automatic rd_expect(input string nm, input logic [11:0] off, input logic [31:0] exp);
      logic [31:0] d;
      logic [1:0]  r;
      axi_rd(off, 4'h1, d, r);
      chk({nm, "_data"}, d, exp);
      chk({nm, "_resp"}, 32'(r), 32'(AXI_OKAY));
   endtask

   task automatic wr_expect(input string nm, input logic [11:0] off, input logic [31:0] data,
                            input logic [1:0] exp_resp);
      logic [1:0] r;
      axi_wr(off, data, 4'hF, 4'h2, r);
      chk({nm, "_resp"}, 32'(r), 32'(exp_resp));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[16];
      logic [11:0] offs[8];
      logic [31:0] d, pend, en, cur, nv, edat;
      logic [1:0]  r, eresp;
      logic [11:0] off;
      logic [3:0]  strb, id;
      int          beats, n;

      mosi = '0;
      irqs = '0;
      rst  = 1'b1;
      #1;
      tick; tick;
      rst = 1'b0;
      tick;

      // reset state
      chk1("rst_awready", miso.awready, 1'b1);
      chk1("rst_wready",  miso.wready,  1'b1);
      chk1("rst_arready", miso.arready, 1'b1);
      chk1("rst_bvalid",  miso.bvalid,  1'b0);
      chk1("rst_rvalid",  miso.rvalid,  1'b0);
      chk1("rst_rlast",   miso.rlast,   1'b0);
      chk1("rst_irq_o",   irq_o,        1'b0);

      // register-access table, no IRQ activity
      tbl[0]  = '{1'b0, IRQ_OFF_PENDING, 32'h0,         AXI_OKAY,   32'h0};
      tbl[1]  = '{1'b0, IRQ_OFF_ENABLE,  32'h0,         AXI_OKAY,   32'h0};
      tbl[2]  = '{1'b1, IRQ_OFF_ENABLE,  32'h5,         AXI_OKAY,   32'h0};
      tbl[3]  = '{1'b0, IRQ_OFF_ENABLE,  32'h0,         AXI_OKAY,   32'h5};
      tbl[4]  = '{1'b1, IRQ_OFF_ENABLE,  32'hFFFF_FFFF, AXI_OKAY,   32'h0};
      tbl[5]  = '{1'b0, IRQ_OFF_ENABLE,  32'h0,         AXI_OKAY,   MASK};
      tbl[6]  = '{1'b0, IRQ_OFF_CLEAR,   32'h0,         AXI_OKAY,   32'h0};
      tbl[7]  = '{1'b0, IRQ_OFF_RAW,     32'h0,         AXI_OKAY,   32'h0};
      tbl[8]  = '{1'b1, IRQ_OFF_PENDING, 32'h5A,        AXI_SLVERR, 32'h0};
      tbl[9]  = '{1'b1, IRQ_OFF_RAW,     32'h1,         AXI_SLVERR, 32'h0};
      tbl[10] = '{1'b1, 12'h010,         32'h1,         AXI_SLVERR, 32'h0};
      tbl[11] = '{1'b0, 12'h010,         32'h0,         AXI_SLVERR, 32'h0};
      tbl[12] = '{1'b1, 12'hFFC,         32'h7,         AXI_SLVERR, 32'h0};
      tbl[13] = '{1'b1, IRQ_OFF_ENABLE,  32'h0,         AXI_OKAY,   32'h0};
      tbl[14] = '{1'b0, IRQ_OFF_ENABLE,  32'h0,         AXI_OKAY,   32'h0};
      tbl[15] = '{1'b0, IRQ_OFF_PENDING, 32'h0,         AXI_OKAY,   32'h0};
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr) begin
            axi_wr(tbl[i].off, tbl[i].data, 4'hF, 4'(i), r);
            chk($sformatf("vec%0d_bresp", i), 32'(r), 32'(tbl[i].resp));
         end else begin
            axi_rd(tbl[i].off, 4'(i), d, r);
            chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(tbl[i].resp));
            chk($sformatf("vec%0d_rdata", i), d, tbl[i].rdata);
         end
         chk1($sformatf("vec%0d_irq_o", i), irq_o, 1'b0);
      end

      // edge -> PENDING -> irq_o two cycles later
      wr_expect("en1", IRQ_OFF_ENABLE, 32'h1, AXI_OKAY);
      irqs.irq_vcs = NS'(1);
      tick;
      chk1("edge_irq_o_c1", irq_o, 1'b0);
      tick;
      chk1("edge_irq_o_c2", irq_o, 1'b1);
      irqs.irq_vcs = '0;
      rd_expect("edge_pending", IRQ_OFF_PENDING, 32'h1);

      // CLEAR lands on the same edge as a new rising edge: set wins
      mosi.awid = 4'h2; mosi.awaddr = BASE | 32'(IRQ_OFF_CLEAR); mosi.awlen = 8'd0;
      mosi.awvalid = 1'b1;
      mosi.wdata = 32'h1; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
      mosi.bready = 1'b0;
      tick;
      mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
      irqs.irq_vcs = NS'(1);
      tick;
      chk1("simul_bvalid", miso.bvalid, 1'b1);
      chk1("simul_irq_o", irq_o, 1'b1);
      mosi.bready = 1'b1;
      tick;
      mosi.bready = 1'b0;
      chk1("simul_bvalid_done", miso.bvalid, 1'b0);
      chk1("simul_irq_o_after", irq_o, 1'b1);
      irqs.irq_vcs = '0;
      rd_expect("simul_pending", IRQ_OFF_PENDING, 32'h1);

      // RO write rejected, state untouched
      wr_expect("ro_pending", IRQ_OFF_PENDING, 32'h5A, AXI_SLVERR);
      rd_expect("ro_pending_kept", IRQ_OFF_PENDING, 32'h1);
      wr_expect("hole_0x10", 12'h010, 32'h1, AXI_SLVERR);
      wr_expect("clr_plain", IRQ_OFF_CLEAR, 32'h1, AXI_OKAY);
      rd_expect("clr_pending", IRQ_OFF_PENDING, 32'h0);
      chk1("clr_irq_o", irq_o, 1'b0);

      // W three cycles ahead of AW, bready held low four cycles
      mosi.wdata = 32'h6; mosi.wstrb = 4'hF; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
      mosi.bready = 1'b0;
      tick;
      mosi.wvalid = 1'b0;
      chk1("wfirst_wready", miso.wready, 1'b0);
      chk1("wfirst_awready", miso.awready, 1'b1);
      tick; tick;
      mosi.awid = 4'h5; mosi.awaddr = BASE | 32'(IRQ_OFF_ENABLE); mosi.awlen = 8'd0;
      mosi.awvalid = 1'b1;
      tick;
      mosi.awvalid = 1'b0;
      chk1("wfirst_bvalid_early", miso.bvalid, 1'b0);
      tick;
      for (int k = 0; k < 4; k++) begin
         chk1($sformatf("wfirst_bvalid%0d", k), miso.bvalid, 1'b1);
         chk($sformatf("wfirst_bresp%0d", k), 32'(miso.bresp), 32'(AXI_OKAY));
         chk($sformatf("wfirst_bid%0d", k), 32'(miso.bid), 32'h5);
         chk1($sformatf("wfirst_awready%0d", k), miso.awready, 1'b0);
         tick;
      end
      mosi.bready = 1'b1;
      tick;
      mosi.bready = 1'b0;
      chk1("wfirst_bvalid_done", miso.bvalid, 1'b0);
      rd_expect("wfirst_enable", IRQ_OFF_ENABLE, 32'h6);

      // two-beat write burst: both beats consumed, SLVERR, no update
      mosi.awid = 4'h7; mosi.awaddr = BASE | 32'(IRQ_OFF_ENABLE); mosi.awlen = 8'd1;
      mosi.awvalid = 1'b1;
      mosi.wdata = 32'h1; mosi.wlast = 1'b0; mosi.wvalid = 1'b1; mosi.bready = 1'b1;
      tick;
      mosi.awvalid = 1'b0;
      chk1("burst_wready_b2", miso.wready, 1'b1);
      mosi.wlast = 1'b1;
      tick;
      mosi.wvalid = 1'b0;
      n = 0;
      while (!miso.bvalid && n < 20) begin tick; n++; end
      chk1("burst_bvalid", miso.bvalid, 1'b1);
      chk("burst_bresp", 32'(miso.bresp), 32'(AXI_SLVERR));
      chk("burst_bid", 32'(miso.bid), 32'h7);
      tick;
      mosi.bready = 1'b0;
      mosi.awlen = 8'd0;
      rd_expect("burst_enable", IRQ_OFF_ENABLE, 32'h6);

      // four-beat read burst, rready toggling
      mosi.arid = 4'h3; mosi.araddr = BASE | 32'(IRQ_OFF_PENDING); mosi.arlen = 8'd3;
      mosi.arvalid = 1'b1; mosi.rready = 1'b0;
      tick;
      mosi.arvalid = 1'b0;
      beats = 0;
      n = 0;
      while (beats < 4 && n < 40) begin
         mosi.rready = n[0];
         if (miso.rvalid) begin
            chk($sformatf("rburst_rresp%0d", n), 32'(miso.rresp), 32'(AXI_SLVERR));
            chk($sformatf("rburst_rdata%0d", n), miso.rdata, 32'h0);
            chk($sformatf("rburst_rid%0d", n), 32'(miso.rid), 32'h3);
            chk1($sformatf("rburst_rlast%0d", n), miso.rlast, beats == 3);
            if (mosi.rready) beats++;
         end
         tick;
         n++;
      end
      mosi.rready = 1'b0;
      mosi.arlen = 8'd0;
      chk("rburst_beats", 32'(beats), 32'd4);
      chk1("rburst_rvalid_end", miso.rvalid, 1'b0);

      // reset during W_RESP; level held across release must not set PENDING
      wr_expect("rst_en", IRQ_OFF_ENABLE, 32'h2, AXI_OKAY);
      irqs.irq_vcs = NS'(2);
      tick; tick;
      chk1("rst_pre_irq_o", irq_o, 1'b1);
      irqs.irq_vcs = NS'(4);
      tick; tick;
      mosi.awid = 4'h9; mosi.awaddr = BASE | 32'(IRQ_OFF_ENABLE);
      mosi.awvalid = 1'b1;
      mosi.wdata = 32'h7; mosi.wlast = 1'b1; mosi.wvalid = 1'b1; mosi.bready = 1'b0;
      tick;
      mosi.awvalid = 1'b0; mosi.wvalid = 1'b0;
      tick;
      chk1("rst_pre_bvalid", miso.bvalid, 1'b1);
      rst = 1'b1;
      #1;
      chk1("rst_async_bvalid", miso.bvalid, 1'b0);
      chk1("rst_async_irq_o", irq_o, 1'b0);
      tick;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         chk1($sformatf("rst_no_bvalid%0d", k), miso.bvalid, 1'b0);
         chk1($sformatf("rst_irq_o%0d", k), irq_o, 1'b0);
      end
      chk1("rst_post_awready", miso.awready, 1'b1);
      chk1("rst_post_arready", miso.arready, 1'b1);
      rd_expect("rst_enable", IRQ_OFF_ENABLE, 32'h0);
      rd_expect("rst_pending", IRQ_OFF_PENDING, 32'h0);
      rd_expect("rst_raw", IRQ_OFF_RAW, 32'h4);
      irqs.irq_vcs = '0;
      tick; tick;
      irqs.irq_vcs = NS'(4);
      tick; tick;
      rd_expect("rst_rearm_pending", IRQ_OFF_PENDING, 32'h4);

      // random traffic against a transaction-level model
      irqs.irq_vcs = '0;
      tick; tick;
      wr_expect("rnd_init_clr", IRQ_OFF_CLEAR, 32'hFFFF_FFFF, AXI_OKAY);
      wr_expect("rnd_init_en", IRQ_OFF_ENABLE, 32'h0, AXI_OKAY);
      pend = 0; en = 0; cur = 0;
      offs[0] = IRQ_OFF_PENDING; offs[1] = IRQ_OFF_ENABLE; offs[2] = IRQ_OFF_CLEAR;
      offs[3] = IRQ_OFF_RAW; offs[4] = 12'h010; offs[5] = IRQ_OFF_ENABLE;
      offs[6] = IRQ_OFF_CLEAR; offs[7] = 12'h7F0;
      for (int it = 0; it < 200; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               nv = $urandom & MASK;
               pend = pend | (nv & ~cur);
               cur = nv;
               irqs.irq_vcs = nv[NS-1:0];
               tick; tick;
            end
            1: begin
               off  = offs[$urandom_range(0, 7)];
               d    = $urandom;
               strb = ($urandom_range(0, 3) == 0) ? 4'hE : 4'hF;
               id   = 4'($urandom);
               axi_wr(off, d, strb, id, r);
               eresp = (off == IRQ_OFF_ENABLE || off == IRQ_OFF_CLEAR) ? AXI_OKAY : AXI_SLVERR;
               if (off == IRQ_OFF_ENABLE && strb[0]) en = d & MASK;
               if (off == IRQ_OFF_CLEAR && strb[0])  pend = pend & ~d;
               chk($sformatf("rnd%0d_bresp", it), 32'(r), 32'(eresp));
            end
            default: begin
               off = offs[$urandom_range(0, 7)];
               id  = 4'($urandom);
               axi_rd(off, id, d, r);
               eresp = AXI_OKAY;
               case (off)
                  IRQ_OFF_PENDING: edat = pend;
                  IRQ_OFF_ENABLE:  edat = en;
                  IRQ_OFF_CLEAR:   edat = 0;
                  IRQ_OFF_RAW:     edat = cur;
                  default: begin edat = 0; eresp = AXI_SLVERR; end
               endcase
               chk($sformatf("rnd%0d_rdata", it), d, edat);
               chk($sformatf("rnd%0d_rresp", it), 32'(r), 32'(eresp));
            end
         endcase
         chk1($sformatf("rnd%0d_irq_o", it), irq_o, |(pend & en));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tile_irq_ctrl.md
TILE_IRQ_CTRL -- requirements
Module: tile_irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default N_VIRT_CHN, meaning the number of NoC IRQ sources.
REQ-002 SHALL have parameter BASE_ADDR, default 32'hB000_0000, meaning the register window base (4 KB window).
REQ-003 SHALL have port clk_core  input  1  single clock for all logic.
REQ-004 SHALL have port arst_core  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port axi_mosi  input  s_axi_mosi_t  AXI4 slave request from the tile interconnect.
REQ-006 SHALL have port axi_miso  output  s_axi_miso_t  AXI4 slave response to the tile interconnect.
REQ-007 SHALL have port irqs_noc  input  s_irq_ni_t  NoC interrupt bundle; irq_vcs[N_SRC-1:0] are the sources.
REQ-008 SHALL have port irq_o  output  1  level interrupt to the core irq_i.

Function
REQ-009 SHALL provide registers at offset 0x00 PENDING (RO), 0x04 ENABLE (RW), 0x08 CLEAR (W1C, reads 0) and 0x0C RAW (RO, synchronised irq_vcs); bits above N_SRC read 0.
REQ-010 SHALL set PENDING[i] on a rising edge of irq_vcs[i], detected against a registered copy, one cycle after the edge.
REQ-011 SHALL clear PENDING[i] on a CLEAR write with wdata[i]=1 and wstrb[0]=1; a simultaneous set and clear of the same bit resolves as set.
REQ-012 SHALL drive irq_o from a register equal to |(PENDING & ENABLE), so irq_o rises one cycle after PENDING/ENABLE update.
REQ-013 SHALL implement the write path as FSM W_IDLE -> W_RESP -> W_IDLE; awready and wready are high only in W_IDLE, AW and W accepted in either order or the same cycle, each latched until both are held.
REQ-014 SHALL enter W_RESP the cycle after both AW and W (wlast=1) are held, apply the register write on that transition, and hold bvalid with bid=awid until bready.
REQ-015 SHALL, for awlen!=0, consume all W beats up to wlast, perform no register write, and respond bresp=SLVERR.
REQ-016 SHALL respond SLVERR for writes to unmapped offsets or to RO registers without altering state; OKAY otherwise.
REQ-017 SHALL implement the read path as FSM R_IDLE -> R_DATA -> R_IDLE; arready high only in R_IDLE; rdata captured at AR handshake.
REQ-018 SHALL in R_DATA return arlen+1 beats with rid=arid, an 8-bit beat counter, rlast on the final beat, advancing only on rvalid&rready.
REQ-019 SHALL return rresp=SLVERR and rdata=0 on every beat when arlen!=0 or the offset is unmapped.
REQ-020 SHALL keep read and write FSMs independent; a read concurrent with a write sees the pre-write register value.
REQ-021 SHALL hold rvalid, rdata and rlast stable while rready is low, and bvalid/bresp while bready is low.

Reset
REQ-022 SHALL on arst_core assertion set PENDING=0, ENABLE=0, edge registers=0, irq_o=0, both FSMs to IDLE, and awready=wready=arready=1 after release, bvalid=rvalid=rlast=0.
REQ-023 SHALL abandon any in-flight transaction on reset mid-operation without issuing a response after release.
REQ-024 SHALL not set PENDING for an irq_vcs level already high at reset release until it falls and rises again.

Structure
REQ-025 SHALL place register offsets, BASE_ADDR default and the OKAY/SLVERR encodings in ravenoc_pkg-compatible shared package mpsoc_pkg.
REQ-026 SHALL instantiate one sub-module tile_irq_edge per source (edge detect + pending bit with set-priority clear).
REQ-027 SHALL be instantiated as interconnect slave 3 of the tile at BASE_ADDR with 12-bit address width.

Verification
REQ-028 SHALL cover: ENABLE=0x1, pulse irq_vcs[0] -> PENDING reads 0x1, irq_o high 2 cycles after edge.
REQ-029 SHALL cover: write CLEAR=0x1 in the same cycle as a new irq_vcs[0] edge -> PENDING[0] stays 1, irq_o stays high.
REQ-030 SHALL cover: W beat presented 3 cycles before AW, bready low 4 cycles -> single write, bvalid held 4 cycles, bresp=OKAY.
REQ-031 SHALL cover: read arlen=3 at 0x00 -> 4 beats SLVERR, rdata=0, rlast only on beat 4, rready toggled each cycle.
REQ-032 SHALL cover: write 0x5A to 0x00 (RO) -> bresp=SLVERR, PENDING unchanged; write to 0x10 -> SLVERR.
REQ-033 SHALL cover: assert arst_core during W_RESP with bready low -> bvalid=0, irq_o=0, ENABLE=0 after release.
